fifo_rd_stream_adapter: RTL and testbench

//  Read-side companion of async_fifo, in the rd_clk domain. Drives async_fifo rd_en and

---
 rtl/fifo_rd_stream_adapter_pkg.sv | 14 +
 rtl/rd_out_buffer.sv | 92 +++++++++
 rtl/fifo_rd_stream_adapter.sv | 90 +++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared defaults and index-width helper for the async_fifo read-side
// stream adapter and its output buffer.
package fifo_rd_stream_adapter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUF_DEPTH  = 2;
    localparam int DEF_CNT_WIDTH  = 16;

    // Bits needed to index n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_out_buffer.sv
// Circular register buffer of BUF_DEPTH words with push/pop, occupancy count,
// head-word output and a sticky overflow/underflow error flag.
// Ports: clk, rst_n (async low), clr (sync clear), push/din, pop, dout (head),
//        count (occupancy), err (sticky).
module rd_out_buffer
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int BUF_DEPTH  = DEF_BUF_DEPTH,
    localparam int PW         = idx_width(BUF_DEPTH),
    localparam int CW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;
    logic                  full, empty;
    logic                  do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count_q == CW'(BUF_DEPTH));
        empty   = (count_q == '0);
        // A full buffer can still take a word on the edge its head leaves.
        do_push = push & (~full | pop);
        do_pop  = pop & ~empty;

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q | (push & full & ~pop) | (pop & empty);

        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = din;
                tail_d        = ptr_inc(tail_q);
            end
            if (do_pop) begin
                head_d = ptr_inc(head_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side companion of async_fifo: issues rd_en, captures data_out one cycle
// later into rd_out_buffer, and presents a first-word-fall-through stream.
// Ports: rd_clk, rd_rst_n (async low), fifo_empty/fifo_rd_en/fifo_data (FIFO
//        side), flush, m_valid/m_ready/m_data (stream), word_cnt, stall_cnt, err.
module fifo_rd_stream_adapter
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic                  err
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    logic                 run_q, run_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]        count;
    logic [OW-1:0]        occupancy;
    logic                 pop;

    rd_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .clr   (flush),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_data),
        .dout  (m_data),
        .count (count),
        .err   (err)
    );

    assign m_valid = (count != '0);

    always_comb begin
        pop = m_valid & m_ready;
        // Words already owned (buffered + in flight) after this edge's pop.
        occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);
        // run_q keeps rd_en low while in reset and until the first edge after.
        // m_ready reaches rd_en combinationally through pop by design.
        fifo_rd_en = run_q & ~fifo_empty & ~flush
                   & (occupancy < OW'(BUF_DEPTH));

        run_d      = 1'b1;
        inflight_d = fifo_rd_en;
        word_cnt_d = word_cnt_q + CNT_WIDTH'(pop);

        stall_cnt_d = stall_cnt_q;
        if (m_valid & ~m_ready & ~&stall_cnt_q) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            run_q       <= 1'b0;
            inflight_q  <= 1'b0;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            run_q       <= run_d;
            inflight_q  <= inflight_d;
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter: behavioural async_fifo read
// model, queue-based reference model, directed table and random phases.
module tb_fifo_rd_stream_adapter;

    localparam int DEPTH = 2;

    logic       rd_clk = 1'b0;
    logic       rd_rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       flush;
    logic       m_ready;

    logic        fifo_rd_en, m_valid, err;
    logic [7:0]  m_data;
    logic [15:0] word_cnt, stall_cnt;

    logic        fifo_rd_en_w, m_valid_w, err_w;
    logic [7:0]  m_data_w;
    logic [3:0]  word_cnt_w, stall_cnt_w;

    always #6 rd_clk = ~rd_clk;

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (DEPTH),
        .CNT_WIDTH  (16)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .word_cnt   (word_cnt),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (DEPTH),
        .CNT_WIDTH  (4)
    ) dut_w (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en_w),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid_w),
        .m_ready    (m_ready),
        .m_data     (m_data_w),
        .word_cnt   (word_cnt_w),
        .stall_cnt  (stall_cnt_w),
        .err        (err_w)
    );

    // Reference model: every word fetched from the FIFO and not yet
    // delivered or flushed, stamped with the edge that fetched it.
    typedef struct {
        logic [7:0] w;
        int         e;
    } fetch_t;

    fetch_t q[$];
    int     rd_ptr, wr_ptr, edge_n;
    bit     run;
    int     exp_wcnt, exp_stall;
    int     checks, failures;
    logic       s_valid, s_rd;
    logic [7:0] s_data;

    typedef struct {
        bit         fe;
        bit         rdy;
        bit         fl;
        bit         e_rd;
        bit         e_valid;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit fe, input bit rdy, input bit fl);
        bit         ev, ep, er, act_rd;
        logic [7:0] ed;
        int         sw;
        @(negedge rd_clk);
        fifo_empty = fe || (rd_ptr >= wr_ptr);
        m_ready    = rdy;
        flush      = fl;
        #1;
        ev = (q.size() > 0) && (q[0].e < edge_n);
        ed = ev ? q[0].w : 8'h00;
        ep = ev && rdy;
        er = run && !fifo_empty && !fl && ((q.size() - int'(ep)) < DEPTH);
        chk("m_valid", 32'(m_valid), 32'(ev));
        if (ev) chk("m_data", 32'(m_data), 32'(ed));
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(er));
        chk("fifo_rd_en_w", 32'(fifo_rd_en_w), 32'(er));
        chk("err", 32'(err), 32'(0));
        chk("err_w", 32'(err_w), 32'(0));
        s_valid = m_valid;
        s_data  = m_data;
        s_rd    = fifo_rd_en;
        act_rd  = fifo_rd_en;
        @(posedge rd_clk);
        edge_n++;
        #1;
        if (ep) begin
            void'(q.pop_front());
            exp_wcnt++;
        end
        if (ev && !rdy && exp_stall < 65535) exp_stall++;
        if (fl) q.delete();
        if (act_rd) begin
            q.push_back('{w: 8'(rd_ptr), e: edge_n});
            fifo_data = 8'(rd_ptr);
            rd_ptr++;
        end
        run = 1'b1;
        sw  = (exp_stall > 15) ? 15 : exp_stall;
        chk("word_cnt", 32'(word_cnt), 32'(exp_wcnt % 65536));
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("word_cnt_w", 32'(word_cnt_w), 32'(exp_wcnt % 16));
        chk("stall_cnt_w", 32'(stall_cnt_w), 32'(sw));
    endtask

    task automatic do_reset(input int avail);
        @(negedge rd_clk);
        rd_rst_n   = 1'b0;
        fifo_empty = 1'b0;
        m_ready    = 1'b0;
        flush      = 1'b0;
        q.delete();
        run       = 1'b0;
        exp_wcnt  = 0;
        exp_stall = 0;
        rd_ptr    = 0;
        wr_ptr    = avail;
        fifo_data = 8'h00;
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_word_cnt", 32'(word_cnt), 32'(0));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rd_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, reads, nxt;
        bit found;
        checks   = 0;
        failures = 0;
        edge_n   = 0;
        rd_rst_n = 1'b0;
        fifo_empty = 1'b0;
        m_ready  = 1'b0;
        flush    = 1'b0;
        fifo_data = 8'h00;

        //            fe rdy fl  rd val data
        tbl[0]  = '{0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 0, 1, 0, 8'h00};
        tbl[2]  = '{0, 1, 0, 1, 0, 8'h00};
        tbl[3]  = '{0, 1, 0, 1, 1, 8'h00};
        tbl[4]  = '{0, 1, 0, 1, 1, 8'h01};
        tbl[5]  = '{0, 1, 0, 1, 1, 8'h02};
        tbl[6]  = '{0, 0, 0, 0, 1, 8'h03};
        tbl[7]  = '{0, 0, 0, 0, 1, 8'h03};
        tbl[8]  = '{0, 1, 0, 1, 1, 8'h03};
        tbl[9]  = '{0, 1, 0, 1, 1, 8'h04};
        tbl[10] = '{0, 1, 0, 1, 1, 8'h05};

        // Reset, start latency and early backpressure
        do_reset(64);
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].fe, tbl[i].rdy, tbl[i].fl);
            chk($sformatf("tbl%0d_rd", i), 32'(s_rd), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid),
                32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_data", i), 32'(s_data),
                    32'(tbl[i].e_data));
        end

        // Streaming 0x00..0x1F at one word per cycle
        do_reset(32);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 1, 0);
            n++;
            if (exp_wcnt == 32) break;
        end
        chk("stream_cycles", 32'(n), 32'(35));
        chk("stream_word_cnt", 32'(word_cnt), 32'(32));

        // Backpressure: two reads, head held, ten stall cycles
        do_reset(64);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            reads += int'(s_rd);
            if (s_valid) break;
        end
        repeat (9) begin
            cycle(0, 0, 0);
            reads += int'(s_rd);
            chk("bp_hold", 32'(s_data), 32'(0));
        end
        chk("bp_reads", 32'(reads), 32'(2));
        chk("bp_stall_cnt", 32'(stall_cnt), 32'(10));
        repeat (40) cycle(0, 1, 0);
        chk("bp_word_cnt", 32'(word_cnt), 32'(exp_wcnt));

        // Empty pulses every third cycle with random ready
        do_reset(1000);
        for (int i = 0; i < 300; i++) begin
            cycle(i % 3 == 2, 1'($urandom_range(0, 1)), 0);
        end

        // Flush with one buffered + in flight, then with two buffered
        for (int v = 0; v < 2; v++) begin
            do_reset(64);
            repeat (4) cycle(0, 1, 0);
            repeat (v) cycle(0, 0, 0);
            cycle(0, 0, 1);
            nxt = rd_ptr;
            cycle(0, 1, 0);
            chk("flush_valid", 32'(s_valid), 32'(0));
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                cycle(0, 1, 0);
                if (s_valid) begin
                    chk("flush_next", 32'(s_data), 32'(nxt));
                    found = 1'b1;
                    break;
                end
            end
            chk("flush_seen", 32'(found), 32'(1));
        end

        // Counter wrap (4-bit instance) and saturation
        do_reset(64);
        for (int i = 0; i < 50; i++) begin
            cycle(0, 1, 0);
            if (exp_wcnt == 17) break;
        end
        chk("wrap_word_cnt_w", 32'(word_cnt_w), 32'(1));
        chk("wrap_word_cnt", 32'(word_cnt), 32'(17));
        repeat (20) cycle(0, 0, 0);
        chk("sat_stall_cnt_w", 32'(stall_cnt_w), 32'(15));
        chk("sat_stall_cnt", 32'(stall_cnt), 32'(20));

        // Random mix: trickling writes, empty, ready and rare flush
        do_reset(0);
        for (int i = 0; i < 400; i++) begin
            wr_ptr += int'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
        end

        // Reset in the middle of traffic, then resume
        do_reset(64);
        repeat (20) cycle(0, 1'($urandom_range(0, 1)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
